// File: rtl/display_pkg.sv
// Shared display constants: blank pattern, active-low hex glyphs
// and a one-hot helper used by the digit scanners.
package display_pkg;

  localparam int MAX_DIG = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [7:0] {
    GLYPH_0 = 8'hC0,
    GLYPH_1 = 8'hF9,
    GLYPH_2 = 8'hA4,
    GLYPH_3 = 8'hB0,
    GLYPH_4 = 8'h99,
    GLYPH_5 = 8'h92,
    GLYPH_6 = 8'h82,
    GLYPH_7 = 8'hF8,
    GLYPH_8 = 8'h80,
    GLYPH_9 = 8'h90,
    GLYPH_A = 8'h88,
    GLYPH_B = 8'h83,
    GLYPH_C = 8'hC6,
    GLYPH_D = 8'hA1,
    GLYPH_E = 8'h86,
    GLYPH_F = 8'h8E
  } glyph_e;

  function automatic logic [MAX_DIG-1:0] f_onehot(
    input int idx,
    input int n
  );
    logic [MAX_DIG-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < MAX_DIG)
      v[idx[3:0]] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] f_glyph(
    input logic [3:0] hex
  );
    logic [7:0] g;
    g = SEG_BLANK;
    unique case (hex)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      4'hF: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/scan_7seg_n_blink_ctrl.sv
// Blink timing: counts frame wraps and toggles the visible phase
// every BLINK_PERIOD frames; a zero period pins the phase visible.
module blink_ctrl #(
  parameter int BLW = 8
) (
  input  logic           CLK,
  input  logic           RSTX,
  input  logic           frame_wrap,
  input  logic [BLW-1:0] BLINK_PERIOD,
  output logic           phase
);

  logic [BLW-1:0] bcnt;
  logic           off;
  logic           hit;

  always_comb begin
    off = (BLINK_PERIOD == '0);
    hit = (bcnt >= BLINK_PERIOD - 1'b1);
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (off) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (frame_wrap) begin
      if (hit) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt  <= bcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_7seg_n.sv
// N-digit multiplexed 7-segment scanner with brightness, guard
// blanking, per-digit blink and frame-coherent digit shadowing.
module scan_7seg_n #(
  parameter int NDIG  = 4,
  parameter int BW    = 8,
  parameter int BLW   = 8,
  parameter int GUARD = 2
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic [BW-1:0]     TIMEOUT,
  input  logic [BW-1:0]     BRIGHT,
  input  logic [BLW-1:0]    BLINK_PERIOD,
  input  logic [NDIG-1:0]   BLINK_EN,
  input  logic [8*NDIG-1:0] SEG_IN,
  output logic [7:0]        SEG,
  output logic [NDIG-1:0]   DIGIT_SEL,
  output logic              FRAME
);

  import display_pkg::*;

  localparam int IW = $clog2(NDIG);
  localparam int XW = BW + 2;
  localparam logic [XW-1:0] G = XW'(GUARD);
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  logic [BW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   init;
  logic [NDIG-1:0][7:0]   shadow;
  logic                   phase;

  logic                   wrap;
  logic                   last;
  logic                   frame_wrap;
  logic [XW-1:0]          cnt_x;
  logic [XW-1:0]          tmo_x;
  logic [XW-1:0]          bri_x;
  logic                   lit;
  logic [NDIG-1:0]        sel_oh;

  always_comb begin
    wrap       = !(cnt < TIMEOUT);
    last       = (idx == LAST);
    frame_wrap = wrap && last;
  end

  // Widened compares keep short slots from wrapping into a lit window
  always_comb begin
    cnt_x  = XW'(cnt);
    tmo_x  = XW'(TIMEOUT);
    bri_x  = XW'(BRIGHT);
    lit    = (cnt_x >= G)
          && (cnt_x + G <= tmo_x)
          && (cnt_x < G + bri_x)
          && !(BLINK_EN[idx] && !phase);
    sel_oh = NDIG'(f_onehot(int'(idx), NDIG));
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      cnt  <= '0;
      idx  <= '0;
      init <= 1'b1;
    end else begin
      init <= 1'b0;
      if (wrap) begin
        cnt <= '0;
        idx <= last ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX)
      shadow <= '1;
    else if (frame_wrap || init)
      shadow <= SEG_IN;
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      SEG       <= SEG_BLANK;
      DIGIT_SEL <= '0;
      FRAME     <= 1'b0;
    end else begin
      SEG       <= shadow[idx];
      DIGIT_SEL <= lit ? sel_oh : '0;
      FRAME     <= frame_wrap || init;
    end
  end

  blink_ctrl #(
    .BLW (BLW)
  ) u_blink (
    .CLK          (CLK),
    .RSTX         (RSTX),
    .frame_wrap   (frame_wrap),
    .BLINK_PERIOD (BLINK_PERIOD),
    .phase        (phase)
  );

endmodule
